// File: rtl/two_bit_adder_pkg.sv
// Shared types and constants for the registered 2-bit adder.
package two_bit_adder_pkg;

  localparam int RES_W    = 3;
  localparam int NUM_BITS = 2;
  localparam int STAGES   = 1;

  typedef logic [RES_W-1:0]    result_t;
  typedef logic [NUM_BITS-1:0] opnd_t;

  // Golden unsigned sum of two 2-bit operands, zero-extended to 3 bits.
  function automatic result_t ref_add2(input opnd_t a, input opnd_t b);
    return result_t'({1'b0, a} + {1'b0, b});
  endfunction

endpackage

// File: rtl/two_bit_adder_full_adder.sv
// One-bit full adder cell; bit 0 of the adder uses it with cin tied low.
module full_adder
  import two_bit_adder_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = x ^ y ^ cin;
  // Majority of the three inputs.
  assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/two_bit_adder.sv
// Registered 2-bit unsigned adder: scalar operand bits in, scalar result bits
// out, one cycle of latency, valid qualifier travelling alongside the result.
module two_bit_adder
  import two_bit_adder_pkg::*;
#(
  parameter result_t RESULT_RESET = 3'b000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a0,
  input  logic a1,
  input  logic b0,
  input  logic b1,
  input  logic in_valid,
  output logic c,
  output logic s1,
  output logic s0,
  output logic out_valid
);

  opnd_t                 opa, opb;
  logic [NUM_BITS:0]     carry;
  logic [NUM_BITS-1:0]   sum;
  result_t               res_d, res_q;
  logic [STAGES:0]       vld_pipe;

  assign opa      = {a1, a0};
  assign opb      = {b1, b0};
  assign carry[0] = 1'b0;

  // Ripple chain: each bit's carry-out feeds the next bit's carry-in.
  for (genvar i = 0; i < NUM_BITS; i++) begin : g_bit
    full_adder u_fa (
      .x    (opa[i]),
      .y    (opb[i]),
      .cin  (carry[i]),
      .sum  (sum[i]),
      .cout (carry[i+1])
    );
  end

  assign res_d       = {carry[NUM_BITS], sum};
  assign vld_pipe[0] = in_valid;

  // Result register loads only on valid, so operands (even X) are ignored otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= RESULT_RESET;
    end else if (in_valid) begin
      res_q <= res_d;
    end
  end

  // Valid shift register; out_valid is a one-cycle pulse per accepted operand set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[STAGES:1] <= '0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
    end
  end

  assign {c, s1, s0} = res_q;
  assign out_valid   = vld_pipe[STAGES];

endmodule

// File: tb/tb_two_bit_adder.sv
// Directed and randomized checks of two_bit_adder against an arithmetic model.
module tb_two_bit_adder;

  logic clk, rst_n;
  logic a0, a1, b0, b1, in_valid;
  logic c, s1, s0, out_valid;

  int checks = 0;
  int errors = 0;

  // Model state: expected {out_valid, c, s1, s0}.
  logic [2:0] exp_res;
  logic       exp_v;

  two_bit_adder #(.RESULT_RESET(3'b000)) dut (
    .clk(clk), .rst_n(rst_n),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1), .in_valid(in_valid),
    .c(c), .s1(s1), .s0(s0), .out_valid(out_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {out_valid, c, s1, s0};
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: got vld,res=%b_%b expected %b_%b", tag, obs[3], obs[2:0], exp[3], exp[2:0]);
      end
  endtask

  // Drive one cycle of operands, update the model, check one cycle later.
  task automatic step(input string tag, input int a, input int b, input logic v);
    logic [1:0] av, bv;
    av = 2'(a);
    bv = 2'(b);
    @(negedge clk);
    in_valid = v;
    {a1, a0} = av;
    {b1, b0} = bv;
    if (v) exp_res = 3'(a + b);
    exp_v = v;
    @(posedge clk);
    #1;
    chk(tag, {exp_v, exp_res});
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0;
    {a1, a0, b1, b0} = 4'b0000;
    exp_res = 3'b000; exp_v = 1'b0;

    // Reset state before any clock edge.
    #2;
    chk("reset_initial", 4'b0_000);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Exhaustive sweep, back to back.
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        step($sformatf("sweep_a%0d_b%0d", a, b), a, b, 1'b1);

    // Spot values, constants computed by hand.
    step("a1_b2", 1, 2, 1'b1);  chk("a1_b2_const", 4'b1_011);
    step("a2_b2", 2, 2, 1'b1);  chk("a2_b2_const", 4'b1_100);
    step("a3_b3", 3, 3, 1'b1);  chk("a3_b3_const", 4'b1_110);
    step("ripple_a1_b3", 1, 3, 1'b1); chk("ripple_const", 4'b1_100);

    // Hold.
    step("hold_load", 3, 1, 1'b1);
    step("hold_idle", 0, 0, 1'b0); chk("hold_const", 4'b0_100);
    step("hold_idle2", 2, 3, 1'b0);

    // Back-to-back.
    step("b2b_first", 0, 0, 1'b1);  chk("b2b_first_const", 4'b1_000);
    step("b2b_second", 2, 1, 1'b1); chk("b2b_second_const", 4'b1_011);

    // Asynchronous reset mid-run with out_valid high.
    step("pre_reset", 3, 2, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    exp_res = 3'b000; exp_v = 1'b0;
    chk("reset_async", {exp_v, exp_res});
    in_valid = 1'b1; {a1, a0, b1, b0} = 4'b1111;
    @(posedge clk); #1; chk("reset_held1", 4'b0_000);
    @(posedge clk); #1; chk("reset_held2", 4'b0_000);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_reset", 2, 3, 1'b1);

    // Randomized traffic; idle cycles carry X operands.
    for (int i = 0; i < 300; i++) begin
      int ra, rb;
      logic rv;
      ra = int'($urandom_range(3, 0));
      rb = int'($urandom_range(3, 0));
      rv = 1'($urandom_range(1, 0));
      if (rv) begin
        step($sformatf("rand_%0d", i), ra, rb, 1'b1);
      end else begin
        @(negedge clk);
        in_valid = 1'b0;
        {a1, a0, b1, b0} = 4'bxxxx;
        exp_v = 1'b0;
        @(posedge clk);
        #1;
        chk($sformatf("rand_idle_%0d", i), {exp_v, exp_res});
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
